// File: rtl/add8u_share_pkg.sv
// Shared types, widths and the approximate adder golden function for add8u_share_arb.
// Used by the RTL and by the bench scoreboard.
package add8u_share_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int OPW  = 8;
  localparam int RESW = 9;
  localparam int CNTW = 16;

  // Bit 0 is a plain OR; the upper seven bits add with no carry in from bit 0.
  function automatic logic [RESW-1:0] add8u_approx(input logic [OPW-1:0] a,
                                                   input logic [OPW-1:0] b);
    logic [OPW-1:0] upper;
    upper = {1'b0, a[OPW-1:1]} + {1'b0, b[OPW-1:1]};
    return {upper, a[0] | b[0]};
  endfunction

endpackage

// File: rtl/add8u_share_arb_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, wrapping.
// gnt is one-hot and only driven when en is high; idx/found are valid regardless of en.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  // Two passes: indices from ptr upward first, then the wrapped range below ptr.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found = 1'b1;
        idx   = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        found = 1'b1;
        idx   = IDW'(i);
      end
    end
  end

  assign gnt = (en && found) ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/add8u_share_arb.sv
// Time-shares one approximate 8-bit adder among NREQ requesters with round-robin grant.
// Optional grant statistics counters are enabled by defining ADD8U_SHARE_STATS_EN.
module add8u_share_arb
  import add8u_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*8-1:0]  req_a,
  input  logic [NREQ*8-1:0]  req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [8:0]         rsp_sum,
  output logic [IDW-1:0]     rsp_id
`ifdef ADD8U_SHARE_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);

  state_t            state, state_next;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    win_idx;
  logic [NREQ-1:0]   gnt;
  logic              found;
  logic              can_accept;
  logic              handshake;
  logic [OPW-1:0]    op_a, op_b;
  logic [RESW-1:0]   core_sum;

  // rst_n gates the enable so req_ready stays low for the whole reset window.
  assign can_accept = (state == EMPTY) | rsp_ready;
  assign handshake  = can_accept & rst_n & found;
  assign req_ready  = gnt;
  assign rsp_valid  = (state == FULL);

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (can_accept & rst_n),
    .gnt   (gnt),
    .idx   (win_idx),
    .found (found)
  );

  assign op_a     = req_a[int'(win_idx)*OPW +: OPW];
  assign op_b     = req_b[int'(win_idx)*OPW +: OPW];
  assign core_sum = add8u_approx(op_a, op_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (handshake) state_next = FULL;
      FULL: begin
        if (handshake)      state_next = FULL;
        else if (rsp_ready) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  // A drained result with no refill leaves rsp_sum/rsp_id holding stale values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum <= '0;
      rsp_id  <= '0;
      rr_ptr  <= '0;
    end else if (handshake) begin
      rsp_sum <= core_sum;
      rsp_id  <= win_idx;
      rr_ptr  <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
    end
  end

`ifdef ADD8U_SHARE_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        grant_cnt[g*CNTW +: CNTW] <= '0;
      else if (stats_clr)
        grant_cnt[g*CNTW +: CNTW] <= '0;
      else if (gnt[g] && (grant_cnt[g*CNTW +: CNTW] != '1))
        grant_cnt[g*CNTW +: CNTW] <= grant_cnt[g*CNTW +: CNTW] + 1'b1;
    end
  end
`else
  // Statistics disabled: no counter state exists.
`endif

endmodule

// File: tb/tb_add8u_share_arb.sv
// Scoreboard bench for add8u_share_arb: stimulus pushes expected results, a negedge monitor pops them.
// Define ADD8U_SHARE_STATS_EN to also exercise the grant counters.
module tb_add8u_share_arb;
  import add8u_share_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [8:0]        rsp_sum;
  logic [IDW-1:0]    rsp_id;
`ifdef ADD8U_SHARE_STATS_EN
  logic              stats_clr;
  logic [NREQ*16-1:0] grant_cnt;
`endif

  typedef struct {
    logic [IDW-1:0] id;
    logic [8:0]     sum;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  add8u_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
`ifdef ADD8U_SHARE_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] a, input logic [7:0] b,
                               input logic [8:0] exp_sum);
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
    req_valid[id]    = 1'b1;
    expq.push_back('{IDW'(id), exp_sum});
  endtask

  // Waits (bounded) for the grant to id, then drops its valid just after the accepting edge.
  task automatic waitGrant(input int id);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("grant_seen_%0d", id), 32'(got), 32'd1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic syncDrive();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got id=%0d sum=0x%0h expected no response",
                 rsp_id, rsp_sum);
      end else begin
        e = expq.pop_front();
        checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
        checkOutput("rsp_sum", 32'(rsp_sum), 32'(e.sum));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
`ifdef ADD8U_SHARE_STATS_EN
    stats_clr = 1'b0;
`endif

    // Reset values, with every requester asking so req_ready suppression is visible.
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_sum", 32'(rsp_sum), 32'd0);
    checkOutput("rst_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    syncDrive();
    rst_n = 1'b1;

    // Single requests: basic sum, carry into bit 8, no carry out of bit 0, error-of-one case.
    applyStimulus(0, 8'h01, 8'h01, 9'h001);
    waitGrant(0);
    @(negedge clk);
    checkOutput("latency_valid", 32'(rsp_valid), 32'd1);
    syncDrive();
    applyStimulus(2, 8'hFE, 8'h02, 9'h100);
    waitGrant(2);
    applyStimulus(1, 8'hFF, 8'h01, 9'h0FF);
    waitGrant(1);
    applyStimulus(3, 8'h03, 8'h05, 9'h007);
    waitGrant(3);

    // Backpressure: requester 3's result is held while requester 0 waits.
    rsp_ready = 1'b0;
    applyStimulus(0, 8'h10, 8'h20, 9'h030);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_ready", 32'(req_ready), 32'd0);
      checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_sum", 32'(rsp_sum), 32'h007);
      checkOutput("bp_id", 32'(rsp_id), 32'd3);
    end
    syncDrive();
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("drain_grant", 32'(req_ready), 32'b0001);
    syncDrive();
    req_valid[0] = 1'b0;
    @(negedge clk);
    checkOutput("bp_next_valid", 32'(rsp_valid), 32'd1);
    syncDrive();

    // Reset while FULL with requests pending: the held result must vanish.
    rsp_ready = 1'b0;
    req_a[2*8 +: 8] = 8'h55;
    req_b[2*8 +: 8] = 8'hAA;
    req_valid[2]    = 1'b1;
    waitGrant(2);
    req_a[1*8 +: 8] = 8'h0C;
    req_b[1*8 +: 8] = 8'h0A;
    req_a[3*8 +: 8] = 8'h21;
    req_b[3*8 +: 8] = 8'h40;
    req_valid[1]    = 1'b1;
    req_valid[3]    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_ready", 32'(req_ready), 32'd0);
    checkOutput("midrst_sum", 32'(rsp_sum), 32'd0);
    syncDrive();
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    expq.push_back('{IDW'(1), 9'h016});
    expq.push_back('{IDW'(3), 9'h061});
    @(negedge clk);
    checkOutput("post_rst_grant", 32'(req_ready), 32'b0010);
    syncDrive();
    req_valid[1] = 1'b0;
    waitGrant(3);

    // Everyone requesting: grants rotate 0,1,2,3 with one result per cycle.
    req_a = {8'hC8, 8'h7F, 8'h80, 8'h11};
    req_b = {8'h64, 8'h7F, 8'h80, 8'h22};
    for (int r = 0; r < 2; r++) begin
      expq.push_back('{IDW'(0), 9'h033});
      expq.push_back('{IDW'(1), 9'h100});
      expq.push_back('{IDW'(2), 9'h0FD});
      expq.push_back('{IDW'(3), 9'h12C});
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 7) req_valid = '0;
      @(negedge clk);
      checkOutput("rr_throughput", 32'(rsp_valid), 32'd1);
    end
    syncDrive();

`ifdef ADD8U_SHARE_STATS_EN
    stats_clr = 1'b1;
    syncDrive();
    stats_clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(3, 8'h02, 8'h04, 9'h006);
      waitGrant(3);
    end
    @(negedge clk);
    checkOutput("cnt3_ten", 32'(grant_cnt[63:48]), 32'd10);
    checkOutput("cnt0_clr", 32'(grant_cnt[15:0]), 32'd0);
    syncDrive();
    stats_clr = 1'b1;
    applyStimulus(3, 8'h02, 8'h04, 9'h006);
    syncDrive();
    stats_clr    = 1'b0;
    req_valid[3] = 1'b0;
    @(negedge clk);
    checkOutput("cnt3_clr_wins", 32'(grant_cnt[63:48]), 32'd0);
    syncDrive();
`endif

    for (int k = 0; k < 20; k++) begin
      if (expq.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("queue_drained", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add8u_share_arb.md
# add8u_share_arb

Round-robin arbiter and sequencer that time-shares one approximate 8-bit unsigned adder core among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, computes the sum through the shared core, and returns a registered 9-bit result tagged with the requester index on a single valid/ready response port. It sits between the clients of the approximate datapath and the adder, so only one adder instance exists per cluster.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester-id width, equal to clog2(NREQ)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_a  in  NREQ*8  operand A, requester i at [8i+7:8i]
- req_b  in  NREQ*8  operand B, same packing
- rsp_valid  out  1  result register holds a result
- rsp_ready  in  1  consumer accepts the result
- rsp_sum  out  9  adder result, O[8:0]
- rsp_id  out  IDW  index of the requester that produced rsp_sum

## Operation
- Adder core function, the golden model:
  - O[0] = a[0] | b[0].
  - Bits 1..7 form a ripple-carry add of a[7:1] + b[7:1] with carry-in 0. There is no carry from bit 0.
  - O[8] = carry out of bit 7.
  - Worst-case error is 1; it occurs when a[0] and b[0] are both 1.
- FSM states:
  - EMPTY: result register empty.
  - FULL: result register holds an undelivered result.
- Accept condition `can_accept` = (state==EMPTY) | rsp_ready.
  - FULL with rsp_ready=1 drains and refills in the same cycle, giving full throughput.
- Arbitration:
  - Round-robin over req_valid, starting from pointer `rr_ptr`.
  - The winner is the first asserted requester at index ≥ rr_ptr, wrapping modulo NREQ.
  - req_ready[winner] = can_accept. All other req_ready bits are 0.
  - req_ready is combinational from req_valid, rr_ptr and state.
- On handshake (req_valid[w] & req_ready[w]):
  - rsp_sum ← core(req_a[w], req_b[w]); rsp_id ← w.
  - Next state is FULL.
  - rr_ptr ← (w+1) mod NREQ.
- On rsp_valid & rsp_ready with no new grant: next state is EMPTY. rsp_sum and rsp_id hold their stale values.
- With no handshake, rr_ptr does not move.
- Requesters must hold req_a, req_b and req_valid stable until accepted. The block never drops an accepted request.

## Timing
- Latency: rsp_valid is asserted one cycle after the accepting edge.
- Throughput: 1 result per cycle while rsp_ready=1.
- Backpressure: with rsp_ready=0 in FULL, all req_ready=0 and rsp_* hold stable.
- Fairness: under continuous requests from all requesters, each requester is granted once every NREQ grants.
- Reset, asynchronous on the falling edge of rst_n:
  - State goes to EMPTY and rr_ptr to 0.
  - rsp_valid=0, rsp_sum=0, rsp_id=0, req_ready=0 while rst_n=0.
  - Statistics counters clear to 0.
- Reset mid-operation discards the pending result; no response is emitted for it.
- The first grant after reset release can occur in the first clock with rst_n=1.

## Configuration
- `ADD8U_SHARE_STATS_EN` defined:
  - Adds output `grant_cnt`, width NREQ*16, one saturating 16-bit grant counter per requester, packed like req_a.
  - Adds input `stats_clr`: a synchronous clear that overrides a same-cycle increment.
  - Counters stick at 0xFFFF.
- Undefined: no counters and no extra ports. All other behaviour is identical.

## Structure
- Package `add8u_share_pkg`:
  - State enum {EMPTY, FULL}.
  - Localparams for operand width 8, result width 9 and counter width 16.
  - Function `add8u_approx(a,b)` implementing the core function; shared by the RTL and the bench scoreboard.
- Sub-module `rr_arbiter` (parameter NREQ): inputs req, ptr and en; outputs one-hot gnt and the encoded index.
- The adder core is instantiated once in the top level and fed by the granted mux.

## Test plan
- Single request, requester 0, a=0x01, b=0x01, rsp_ready=1 → rsp_valid the next cycle, rsp_sum=0x001, rsp_id=0.
- Requester 2, a=0xFE, b=0x02 → rsp_sum=0x100. Requester 1, a=0xFF, b=0x01 → rsp_sum=0x0FF, showing the no-carry-from-bit-0 behaviour.
- All 4 requesters valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,… with one result per cycle, each sum matching add8u_approx.
- rsp_ready=0 for 3 cycles while FULL → req_ready all 0 and rsp_sum/rsp_id stable. When rsp_ready rises, drain and the next grant occur in the same cycle.
- rst_n pulsed low while FULL with requests pending → rsp_valid=0 immediately. After release, the first grant goes to the lowest-index valid requester (rr_ptr=0).
- With `ADD8U_SHARE_STATS_EN`: 10 grants to requester 3 → grant_cnt[63:48]=10. stats_clr asserted in the same cycle as a grant → counter reads 0.
